fp_addsub_arbiter: RTL and testbench

Two-requester controller that shares one combinational floating-point add/sub unit (`add_sub_main`-class datapath, IEEE 754 single precision) between independent clients. Each request is accepted with a valid/ready handshake and arbitrated round-robin. The arbiter registers the operands into the unit, waits a programmable settle time and captures the result. It then returns the result to the originating requester through a per-requester response handshake. It sits between the instruction/sequencer logic and the FP unit.

---
 rtl/fp_addsub_pkg.sv | 15 +
 rtl/fp_addsub_arbiter_rr_arb2.sv | 30 +++
 rtl/fp_addsub_arbiter.sv | 118 +++++++++++
 tb/tb_fp_addsub_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the FP add/sub arbiter slice.
package fp_addsub_pkg;

    localparam int FP_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fp_addsub_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer moves past the winner on each update strobe.
module rr_arb2
    import fp_addsub_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // ptr = 0 favours requester 0, ptr = 1 favours requester 1
    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11)
            grant = ptr ? 2'b10 : 2'b01;
        else
            grant = req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (update)
            ptr <= grant[0];
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one combinational FP add/sub unit between two requesters, round-robin.
// Optional completion counters (done_cnt0/done_cnt1) with FP_ARB_STATS_EN.
module fp_addsub_arbiter
    import fp_addsub_pkg::*;
#(
    parameter int WIDTH   = FP_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [1:0]           req_op,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [WIDTH-1:0]     resp_result,
    output logic [WIDTH-1:0]     fpu_a,
    output logic [WIDTH-1:0]     fpu_b,
    output logic                 fpu_op,
    input  logic [WIDTH-1:0]     fpu_result
`ifdef FP_ARB_STATS_EN
   ,output logic [15:0]          done_cnt0,
    output logic [15:0]          done_cnt1
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    arb_state_t              state;
    logic [3:0]              cnt;
    logic                    owner;
    logic [WIDTH-1:0]        result_q;
    logic [1:0]              grant;
    logic                    gsel;
    logic                    accept;
    logic                    resp_done;
    logic [1:0][WIDTH-1:0]   a_lane;
    logic [1:0][WIDTH-1:0]   b_lane;

    assign a_lane = req_a;
    assign b_lane = req_b;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .update (accept),
        .grant  (grant)
    );

    assign gsel        = grant[1];
    assign req_ready   = (state == IDLE) ? grant : 2'b00;
    assign accept      = |(req_valid & req_ready);
    assign resp_done   = (state == RESP) && resp_ready[owner];
    assign resp_result = result_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_op     <= OP_ADD;
            result_q   <= '0;
            resp_valid <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_a  <= a_lane[gsel];
                        fpu_b  <= b_lane[gsel];
                        fpu_op <= req_op[gsel];
                        owner  <= gsel;
                        cnt    <= CNT_INIT;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    // operands have been on the unit for LATENCY cycles when cnt hits 0
                    if (cnt == 4'd0) begin
                        result_q   <= fpu_result;
                        resp_valid <= owner ? 2'b10 : 2'b01;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        resp_valid <= 2'b00;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_cnt0 <= '0;
            done_cnt1 <= '0;
        end else if (resp_done) begin
            if (owner)
                done_cnt1 <= done_cnt1 + 16'd1;
            else
                done_cnt0 <= done_cnt0 + 16'd1;
        end
    end
`else
    // completion counters are not built in this configuration
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench: two arbiters (LATENCY 1 and 4) each driving a behavioural FP unit.
module tb_fp_addsub_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid, req_ready, req_op, resp_valid, resp_ready;
    logic [63:0] req_a, req_b;
    logic [31:0] resp_result, fpu_a, fpu_b, fpu_result;
    logic        fpu_op;

    logic [1:0]  q_req_valid, q_req_ready, q_req_op, q_resp_valid, q_resp_ready;
    logic [63:0] q_req_a, q_req_b;
    logic [31:0] q_resp_result, q_fpu_a, q_fpu_b, q_fpu_result;
    logic        q_fpu_op;

`ifdef FP_ARB_STATS_EN
    logic [15:0] done_cnt0, done_cnt1, q_done_cnt0, q_done_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    int last_srv = 1;
    int exp_done0 = 0;
    int exp_done1 = 0;

    fp_addsub_arbiter #(.WIDTH(32), .LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_result(fpu_result)
`ifdef FP_ARB_STATS_EN
       ,.done_cnt0(done_cnt0),
        .done_cnt1(done_cnt1)
`endif
    );

    fp_addsub_arbiter #(.WIDTH(32), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(q_req_valid), .req_ready(q_req_ready),
        .req_a(q_req_a), .req_b(q_req_b), .req_op(q_req_op),
        .resp_valid(q_resp_valid), .resp_ready(q_resp_ready), .resp_result(q_resp_result),
        .fpu_a(q_fpu_a), .fpu_b(q_fpu_b), .fpu_op(q_fpu_op),
        .fpu_result(q_fpu_result)
`ifdef FP_ARB_STATS_EN
       ,.done_cnt0(q_done_cnt0),
        .done_cnt1(q_done_cnt1)
`endif
    );

    // ---- FP unit model: single <-> double conversion and real arithmetic
    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        d = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] unit_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        real ra, rb;
        ra = sp2real(a);
        rb = sp2real(b);
        return real2sp(op ? (ra - rb) : (ra + rb));
    endfunction

    always_comb fpu_result = unit_model(fpu_a, fpu_b, fpu_op);

    // the slow unit only yields a valid sum once its operands have settled for 4 cycles
    logic [64:0] q_prev = '0;
    int          q_stab = 0;
    always @(negedge clk) begin
        if ({q_fpu_a, q_fpu_b, q_fpu_op} != q_prev) q_stab <= 0;
        else if (q_stab < 15) q_stab <= q_stab + 1;
        q_prev <= {q_fpu_a, q_fpu_b, q_fpu_op};
    end
    always_comb q_fpu_result = (q_stab >= 3) ? unit_model(q_fpu_a, q_fpu_b, q_fpu_op) : 32'hDEADBEEF;

    // ---- reference: exact integer arithmetic, encoded to single precision
    function automatic logic [31:0] int2sp(input int v);
        logic [31:0] m, t;
        int p;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 24; i++) if (m[i]) p = i;
        t = m << (23 - p);
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + p), t[22:0]};
    endfunction

    function automatic logic [1:0] arb_exp(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
        return v;
    endfunction

    function automatic int rnd_val();
        return int'($urandom_range(4000)) - 2000;
    endfunction

    // one transaction on the LATENCY=1 instance with `stall` cycles of owner backpressure
    task automatic txn(input int r, input logic [31:0] a, input logic [31:0] b, input logic op,
                       input int stall, input logic [31:0] want);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        req_valid = oh;
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_op[r] = op;
        resp_ready = 2'b00;
        #1;
        checks++;
        if (req_ready !== oh) begin errors++; $display("FAIL txn_grant: got %b want %b", req_ready, oh); end
        @(negedge clk);
        req_valid = 2'b11;
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_op = ~req_op;
        #1;
        checks++;
        if ({fpu_a, fpu_b, fpu_op} !== {a, b, op}) begin
            errors++; $display("FAIL txn_fpu_operands: got %h %h %b want %h %h %b", fpu_a, fpu_b, fpu_op, a, b, op);
        end
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            errors++; $display("FAIL txn_wait: got ready %b valid %b want 00 00", req_ready, resp_valid);
        end
        @(negedge clk);
        for (int s = 0; s < stall; s++) begin
            resp_ready = ~oh;
            #1;
            checks++;
            if (resp_valid !== oh || resp_result !== want) begin
                errors++; $display("FAIL txn_hold: got %b %h want %b %h", resp_valid, resp_result, oh, want);
            end
            @(negedge clk);
        end
        resp_ready = oh;
        req_valid = 2'b00;
        #1;
        checks++;
        if (resp_valid !== oh) begin errors++; $display("FAIL txn_resp_valid: got %b want %b", resp_valid, oh); end
        checks++;
        if (resp_result !== want) begin errors++; $display("FAIL txn_result: got %h want %h", resp_result, want); end
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        checks++;
        if (resp_valid !== 2'b00) begin errors++; $display("FAIL txn_resp_clear: got %b want 00", resp_valid); end
        last_srv = r;
        if (r == 0) exp_done0++; else exp_done1++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = '0;
        q_req_valid = '0; q_req_a = '0; q_req_b = '0; q_req_op = '0; q_resp_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({fpu_a, fpu_b, fpu_op, resp_result, resp_valid, req_ready} !== 101'd0) begin
            errors++; $display("FAIL reset_outputs: got %h %h %b %h %b %b want all zero", fpu_a, fpu_b, fpu_op, resp_result, resp_valid, req_ready);
        end
        checks++;
        if ({q_fpu_a, q_fpu_b, q_fpu_op, q_resp_result, q_resp_valid, q_req_ready} !== 101'd0) begin
            errors++; $display("FAIL reset_outputs4: got %h %h %b %h %b want all zero", q_fpu_a, q_fpu_b, q_fpu_op, q_resp_result, q_resp_valid);
        end
`ifdef FP_ARB_STATS_EN
        checks++;
        if ({done_cnt0, done_cnt1} !== 32'd0) begin
            errors++; $display("FAIL reset_stats: got %0d %0d want 0 0", done_cnt0, done_cnt1);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        req_valid = 2'b11;
        q_req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01 || q_req_ready !== 2'b01) begin
            errors++; $display("FAIL reset_pointer: got %b %b want 01 01", req_ready, q_req_ready);
        end
        req_valid = 2'b00;
        q_req_valid = 2'b00;
        last_srv = 1;
        exp_done0 = 0;
        exp_done1 = 0;
    endtask

    task automatic test_single_add();
        txn(0, 32'h3F800000, 32'h40000000, 1'b0, 0, 32'h40400000);
    endtask

    task automatic test_sub_backpressure();
        txn(1, 32'h40400000, 32'h3F800000, 1'b1, 5, 32'h40000000);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int r, x, y;
            logic op;
            r = int'($urandom_range(1));
            x = rnd_val();
            y = rnd_val();
            op = 1'($urandom_range(1));
            txn(r, int2sp(x), int2sp(y), op, int'($urandom_range(3)), int2sp(op ? x - y : x + y));
        end
    endtask

    // both requesters hold valid for 4 transactions each under random backpressure
    task automatic test_fairness();
        int xs[2], ys[2], nacc[2];
        logic ops[2];
        int ndone, cyc, own;
        bit busy;
        logic [31:0] expv;
        logic [1:0] exp_rdy, ohv;
        ndone = 0; cyc = 0; busy = 0; own = 0; expv = '0;
        for (int g = 0; g < 2; g++) begin
            xs[g] = rnd_val(); ys[g] = rnd_val(); ops[g] = 1'($urandom_range(1)); nacc[g] = 0;
        end
        while (ndone < 8 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                req_valid[g] = (nacc[g] < 4);
                req_a[g*32 +: 32] = int2sp(xs[g]);
                req_b[g*32 +: 32] = int2sp(ys[g]);
                req_op[g] = ops[g];
            end
            resp_ready = 2'($urandom_range(3));
            #1;
            ohv = (own == 0) ? 2'b01 : 2'b10;
            checks++;
            if (resp_valid !== 2'b00 && (!busy || resp_valid !== ohv)) begin
                errors++; $display("FAIL fair_resp_owner: got %b want %b", resp_valid, busy ? ohv : 2'b00);
            end
            if (busy && resp_valid === ohv) begin
                checks++;
                if (resp_result !== expv) begin errors++; $display("FAIL fair_result: got %h want %h", resp_result, expv); end
            end
            exp_rdy = busy ? 2'b00 : arb_exp(req_valid, last_srv);
            checks++;
            if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant: got %b want %b", req_ready, exp_rdy); end
            if (busy && resp_valid === ohv && resp_ready[own]) begin
                busy = 0;
                ndone++;
                if (own == 0) exp_done0++; else exp_done1++;
            end else if (!busy && exp_rdy != 2'b00) begin
                own = exp_rdy[1] ? 1 : 0;
                expv = int2sp(ops[own] ? xs[own] - ys[own] : xs[own] + ys[own]);
                busy = 1;
                last_srv = own;
                nacc[own]++;
                xs[own] = rnd_val(); ys[own] = rnd_val(); ops[own] = 1'($urandom_range(1));
            end
        end
        checks++;
        if (ndone != 8) begin errors++; $display("FAIL fair_timeout: got %0d completions want 8", ndone); end
        @(negedge clk);
        req_valid = 2'b00;
        resp_ready = 2'b00;
    endtask

    task automatic test_settle();
        int x, y;
        logic [31:0] want;
        x = rnd_val(); y = rnd_val();
        want = int2sp(x + y);
        @(negedge clk);
        q_req_valid = 2'b01;
        q_req_a[31:0] = int2sp(x);
        q_req_b[31:0] = int2sp(y);
        q_req_op[0] = 1'b0;
        q_resp_ready = 2'b11;
        #1;
        checks++;
        if (q_req_ready !== 2'b01) begin errors++; $display("FAIL settle_accept: got %b want 01", q_req_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            q_req_valid = 2'b11;
            #1;
            checks++;
            if (q_req_ready !== 2'b00 || q_resp_valid !== 2'b00) begin
                errors++; $display("FAIL settle_wait: cycle %0d got ready %b valid %b want 00 00", c, q_req_ready, q_resp_valid);
            end
        end
        @(negedge clk);
        q_req_valid = 2'b00;
        #1;
        checks++;
        if (q_resp_valid !== 2'b01 || q_resp_result !== want) begin
            errors++; $display("FAIL settle_resp: got %b %h want 01 %h", q_resp_valid, q_resp_result, want);
        end
        @(negedge clk);
        #1;
        checks++;
        if (q_resp_valid !== 2'b00) begin errors++; $display("FAIL settle_clear: got %b want 00", q_resp_valid); end
        q_resp_ready = 2'b00;
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        req_valid = 2'b01;
        req_a[31:0] = 32'h40A00000;
        req_b[31:0] = 32'h3F800000;
        req_op[0] = 1'b0;
        resp_ready = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL midop_accept: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({fpu_a, fpu_b, fpu_op, resp_result, resp_valid, req_ready} !== 101'd0) begin
            errors++; $display("FAIL midop_reset: got %h %h %b %h %b %b want all zero", fpu_a, fpu_b, fpu_op, resp_result, resp_valid, req_ready);
        end
        rst_n = 1'b1;
        last_srv = 1;
        exp_done0 = 0;
        exp_done1 = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (resp_valid !== 2'b00) begin errors++; $display("FAIL midop_no_resp: got %b want 00", resp_valid); end
        end
        resp_ready = 2'b00;
        txn(1, int2sp(7), int2sp(-3), 1'b1, 1, int2sp(10));
    endtask

    // requester 0 alone with resp_ready high issues every LATENCY+2 = 3 cycles
    task automatic test_back_to_back();
        int acc_cyc[$];
        logic [31:0] expq[$];
        int comps, cyc, nacc, x, y;
        logic op;
        comps = 0; cyc = 0; nacc = 0;
        x = rnd_val(); y = rnd_val(); op = 1'($urandom_range(1));
        while (comps < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            req_valid = (nacc < 3) ? 2'b01 : 2'b00;
            req_a[31:0] = int2sp(x);
            req_b[31:0] = int2sp(y);
            req_op[0] = op;
            resp_ready = 2'b11;
            #1;
            if (resp_valid[0] === 1'b1 && expq.size() > 0) begin
                checks++;
                if (resp_result !== expq[0]) begin errors++; $display("FAIL b2b_result: got %h want %h", resp_result, expq[0]); end
                void'(expq.pop_front());
                comps++;
                exp_done0++;
            end
            if (req_ready[0] === 1'b1 && req_valid[0]) begin
                acc_cyc.push_back(cyc);
                expq.push_back(int2sp(op ? x - y : x + y));
                nacc++;
                last_srv = 0;
                x = rnd_val(); y = rnd_val(); op = 1'($urandom_range(1));
            end
        end
        checks++;
        if (comps != 3 || acc_cyc.size() != 3) begin
            errors++; $display("FAIL b2b_timeout: got %0d completions %0d accepts want 3 3", comps, acc_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                    errors++; $display("FAIL b2b_period: got %0d want 3", acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        resp_ready = 2'b00;
    endtask

    task automatic test_stats();
`ifdef FP_ARB_STATS_EN
        @(negedge clk);
        #1;
        checks++;
        if (done_cnt0 !== 16'(exp_done0) || done_cnt1 !== 16'(exp_done1)) begin
            errors++; $display("FAIL stats: got %0d %0d want %0d %0d", done_cnt0, done_cnt1, exp_done0, exp_done1);
        end
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_backpressure();
        test_fairness();
        test_random();
        test_settle();
        test_reset_midop();
        test_back_to_back();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
